// File: rtl/cnn_cfg_master.sv
// Avalon-MM master: writes a CNN job descriptor, starts the job and polls status.
// Optional poll timeout enabled by defining CNN_CFG_TIMEOUT_EN.
module cnn_cfg_master #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 1048576
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_in1,
  input  logic [63:0] cmd_out1,
  input  logic [63:0] cmd_scale,
  input  logic [63:0] cmd_wl,
  input  logic [63:0] cmd_param,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        job_done,
  output logic        job_err
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_START, S_POLL, S_GAP, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [4:0][63:0]  desc_q, desc_d;
  logic [3:0]        k_q, k_d, k_next;
  logic [GW-1:0]     gap_q, gap_d;
  logic [2:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic              wr_ok, rd_ok;
  logic              unused_cfg;

  // Even word index carries the high half: the slave shifts writes in from the low side.
  function automatic logic [31:0] word_of(input logic [4:0][63:0] d, input logic [3:0] k);
    logic [63:0] f;
    f = d[k[3:1]];
    return k[0] ? f[31:0] : f[63:32];
  endfunction

  assign wr_ok  = wr_q && !avm_waitrequest;
  assign rd_ok  = rd_q && !avm_waitrequest;
  assign k_next = k_q + 4'd1;

`ifdef CNN_CFG_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    k_d     = k_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
`ifdef CNN_CFG_TIMEOUT_EN
    to_d    = to_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          desc_d  = {cmd_param, cmd_wl, cmd_scale, cmd_out1, cmd_in1};
          k_d     = '0;
          addr_d  = 3'd0;
          wdata_d = cmd_in1[63:32];
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ok) begin
          if (k_q == 4'd9) begin
            addr_d  = 3'd5;
            wdata_d = 32'h1;
            state_d = S_START;
          end else begin
            k_d     = k_next;
            addr_d  = k_next[3:1];
            wdata_d = word_of(desc_q, k_next);
          end
        end
      end
      S_START: begin
        if (wr_ok) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          state_d = S_POLL;
`ifdef CNN_CFG_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_POLL: begin
        if (rd_ok) begin
          if (!avm_readdata[0]) begin
            rd_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else if (POLL_GAP != 0) begin
            rd_d    = 1'b0;
            gap_d   = GW'(POLL_GAP - 1);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          rd_d    = 1'b1;
          state_d = S_POLL;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef CNN_CFG_TIMEOUT_EN
    // Timeout never cuts a stalled read short and yields to a genuine completion.
    if (state_q == S_POLL || state_q == S_GAP) begin
      to_d = to_q + 32'd1;
      if (to_q == 32'(TIMEOUT - 1) && !(rd_q && avm_waitrequest) && state_d != S_FINISH) begin
        rd_d    = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_FINISH;
      end
    end
`endif
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      desc_q  <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CNN_CFG_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CNN_CFG_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cmd_ready     = ready_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign avm_write     = wr_q;
  assign avm_read      = rd_q;
  assign busy          = busy_q;
  assign job_done      = done_q;
`ifdef CNN_CFG_TIMEOUT_EN
  assign job_err       = err_q;
`else
  assign job_err       = 1'b0;
`endif

  assign unused_cfg = ^{avm_readdata[31:1], 32'(TIMEOUT)};

endmodule
